// File: rtl/trap_sequencer.sv
// ============================================================================
// Module      : trap_sequencer
// Description : Multi-cycle trap / xRET controller. It captures one request,
//               issues the CSR writes for it on the shared bus, then redirects
//               the PC and updates the privilege level.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module trap_sequencer #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            exc_valid,
    input  logic [4:0]      exc_code,
    input  logic [XLEN-1:0] exc_pc,
    input  logic [XLEN-1:0] exc_val,
    input  logic            xret_valid,
    input  logic            xret_is_sret,
    input  logic [1:0]      current_priv,
    input  logic [XLEN-1:0] medeleg,
    input  logic [XLEN-1:0] mstatus_in,
    input  logic [XLEN-1:0] mtvec,
    input  logic [XLEN-1:0] stvec,
    input  logic [XLEN-1:0] mepc,
    input  logic [XLEN-1:0] sepc,
    input  logic            csr_ready,
    output logic            busy,
    output logic            flush,
    output logic            csr_we,
    output logic [11:0]     csr_waddr,
    output logic [XLEN-1:0] csr_wdata,
    output logic            pc_redirect,
    output logic [XLEN-1:0] redirect_pc,
    output logic            priv_we,
    output logic [1:0]      new_priv
);

    localparam logic [2:0] c_ST_IDLE     = 3'd0;
    localparam logic [2:0] c_ST_W_EPC    = 3'd1;
    localparam logic [2:0] c_ST_W_CAUSE  = 3'd2;
    localparam logic [2:0] c_ST_W_TVAL   = 3'd3;
    localparam logic [2:0] c_ST_W_STATUS = 3'd4;
    localparam logic [2:0] c_ST_REDIRECT = 3'd5;

    logic [2:0]      r_state;
    logic            r_to_s;
    logic [XLEN-1:0] r_epc;
    logic [XLEN-1:0] r_cause;
    logic [XLEN-1:0] r_tval;
    logic [XLEN-1:0] r_status;
    logic [XLEN-1:0] r_tgt_pc;
    logic [1:0]      r_tgt_priv;

    logic            w_accept;
    logic            w_to_s;
    logic [XLEN-1:0] w_status_new;
    logic [XLEN-1:0] w_tgt_pc;
    logic [1:0]      w_tgt_priv;

    // Everything the sequence needs is resolved at capture, so later input
    // changes cannot disturb an in-flight sequence.
    always_comb begin
        w_accept     = (r_state == c_ST_IDLE) && (exc_valid || xret_valid);
        w_to_s       = exc_valid && (current_priv != 2'b11) && medeleg[exc_code];
        w_status_new = mstatus_in;
        w_tgt_pc     = '0;
        w_tgt_priv   = 2'b11;
        if (exc_valid) begin
            if (w_to_s) begin
                w_status_new[5] = mstatus_in[1];
                w_status_new[1] = 1'b0;
                w_status_new[8] = current_priv[0];
                w_tgt_pc        = {stvec[XLEN-1:2], 2'b00};
                w_tgt_priv      = 2'b01;
            end else begin
                w_status_new[7]     = mstatus_in[3];
                w_status_new[3]     = 1'b0;
                w_status_new[12:11] = current_priv;
                w_tgt_pc            = {mtvec[XLEN-1:2], 2'b00};
                w_tgt_priv          = 2'b11;
            end
        end else if (xret_is_sret) begin
            w_status_new[1] = mstatus_in[5];
            w_status_new[5] = 1'b1;
            w_status_new[8] = 1'b0;
            w_tgt_pc        = sepc;
            w_tgt_priv      = {1'b0, mstatus_in[8]};
        end else begin
            w_status_new[3]     = mstatus_in[7];
            w_status_new[7]     = 1'b1;
            w_status_new[12:11] = 2'b00;
            w_tgt_pc            = mepc;
            w_tgt_priv          = mstatus_in[12:11];
        end
    end

    logic [2:0]      w_n_state;
    logic            w_n_to_s;
    logic [XLEN-1:0] w_n_epc;
    logic [XLEN-1:0] w_n_cause;
    logic [XLEN-1:0] w_n_tval;
    logic [XLEN-1:0] w_n_status;
    logic [XLEN-1:0] w_n_tgt_pc;
    logic [1:0]      w_n_tgt_priv;

    always_comb begin
        w_n_state = r_state;
        case (r_state)
            c_ST_IDLE: begin
                if (exc_valid)       w_n_state = c_ST_W_EPC;
                else if (xret_valid) w_n_state = c_ST_W_STATUS;
            end
            c_ST_W_EPC:    if (csr_ready) w_n_state = c_ST_W_CAUSE;
            c_ST_W_CAUSE:  if (csr_ready) w_n_state = c_ST_W_TVAL;
            c_ST_W_TVAL:   if (csr_ready) w_n_state = c_ST_W_STATUS;
            c_ST_W_STATUS: if (csr_ready) w_n_state = c_ST_REDIRECT;
            default:       w_n_state = c_ST_IDLE;
        endcase
    end

    assign w_n_to_s     = w_accept ? w_to_s                                : r_to_s;
    assign w_n_epc      = w_accept ? exc_pc                                : r_epc;
    assign w_n_cause    = w_accept ? {{(XLEN-5){1'b0}}, exc_code}          : r_cause;
    assign w_n_tval     = w_accept ? exc_val                               : r_tval;
    assign w_n_status   = w_accept ? w_status_new                          : r_status;
    assign w_n_tgt_pc   = w_accept ? w_tgt_pc                              : r_tgt_pc;
    assign w_n_tgt_priv = w_accept ? w_tgt_priv                            : r_tgt_priv;

    logic            w_o_we;
    logic [11:0]     w_o_addr;
    logic [XLEN-1:0] w_o_data;
    logic [3:0]      w_base;

    // Outputs are decoded from the next state so they can be registered
    // without adding a cycle of latency.
    always_comb begin
        w_o_we   = 1'b0;
        w_o_addr = '0;
        w_o_data = '0;
        w_base   = w_n_to_s ? 4'h1 : 4'h3;
        case (w_n_state)
            c_ST_W_EPC: begin
                w_o_we   = 1'b1;
                w_o_addr = {w_base, 8'h41};
                w_o_data = w_n_epc;
            end
            c_ST_W_CAUSE: begin
                w_o_we   = 1'b1;
                w_o_addr = {w_base, 8'h42};
                w_o_data = w_n_cause;
            end
            c_ST_W_TVAL: begin
                w_o_we   = 1'b1;
                w_o_addr = {w_base, 8'h43};
                w_o_data = w_n_tval;
            end
            c_ST_W_STATUS: begin
                w_o_we   = 1'b1;
                w_o_addr = 12'h300;
                w_o_data = w_n_status;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= c_ST_IDLE;
            r_to_s      <= 1'b0;
            r_epc       <= '0;
            r_cause     <= '0;
            r_tval      <= '0;
            r_status    <= '0;
            r_tgt_pc    <= '0;
            r_tgt_priv  <= '0;
            busy        <= 1'b0;
            flush       <= 1'b0;
            csr_we      <= 1'b0;
            csr_waddr   <= '0;
            csr_wdata   <= '0;
            pc_redirect <= 1'b0;
            redirect_pc <= '0;
            priv_we     <= 1'b0;
            new_priv    <= '0;
        end else begin
            r_state     <= w_n_state;
            r_to_s      <= w_n_to_s;
            r_epc       <= w_n_epc;
            r_cause     <= w_n_cause;
            r_tval      <= w_n_tval;
            r_status    <= w_n_status;
            r_tgt_pc    <= w_n_tgt_pc;
            r_tgt_priv  <= w_n_tgt_priv;
            busy        <= (w_n_state != c_ST_IDLE);
            flush       <= (w_n_state != c_ST_IDLE);
            csr_we      <= w_o_we;
            csr_waddr   <= w_o_addr;
            csr_wdata   <= w_o_data;
            pc_redirect <= (w_n_state == c_ST_REDIRECT);
            priv_we     <= (w_n_state == c_ST_REDIRECT);
            redirect_pc <= (w_n_state == c_ST_REDIRECT) ? w_n_tgt_pc : '0;
            new_priv    <= (w_n_state == c_ST_REDIRECT) ? w_n_tgt_priv : 2'b00;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_trap_sequencer.sv
// ============================================================================
// Module      : tb_trap_sequencer
// Description : Directed bench for trap_sequencer with a transaction-level
//               reference model checked every cycle.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_trap_sequencer;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        exc_valid, xret_valid, xret_is_sret, csr_ready;
    logic [4:0]  exc_code;
    logic [31:0] exc_pc, exc_val, medeleg, mstatus_in, mtvec, stvec, mepc, sepc;
    logic [1:0]  current_priv;
    logic        busy, flush, csr_we, pc_redirect, priv_we;
    logic [11:0] csr_waddr;
    logic [31:0] csr_wdata, redirect_pc;
    logic [1:0]  new_priv;

    always #5 clk = ~clk;

    trap_sequencer #(.XLEN(32)) dut (
        .clk(clk), .reset_n(reset_n), .exc_valid(exc_valid), .exc_code(exc_code),
        .exc_pc(exc_pc), .exc_val(exc_val), .xret_valid(xret_valid),
        .xret_is_sret(xret_is_sret), .current_priv(current_priv), .medeleg(medeleg),
        .mstatus_in(mstatus_in), .mtvec(mtvec), .stvec(stvec), .mepc(mepc), .sepc(sepc),
        .csr_ready(csr_ready), .busy(busy), .flush(flush), .csr_we(csr_we),
        .csr_waddr(csr_waddr), .csr_wdata(csr_wdata), .pc_redirect(pc_redirect),
        .redirect_pc(redirect_pc), .priv_we(priv_we), .new_priv(new_priv)
    );

    int vectors = 0;
    int miscompares = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: a request becomes a list of CSR writes plus a redirect.
    typedef struct packed {
        logic [11:0] a;
        logic [31:0] d;
    } wr_t;

    wr_t         wq[$];
    bit          in_seq = 0;
    logic [31:0] m_pc;
    logic [1:0]  m_priv;
    int          cyc = 0, acc_cyc = 0;
    logic [31:0] obs [int];
    logic [31:0] obs_pc;
    logic [1:0]  obs_priv;
    int          obs_lat = 0, n_redir = 0;

    function automatic logic [31:0] trap_status(logic [31:0] ms, logic [1:0] p, bit s);
        if (s) return (ms & ~32'h122) | (ms[1] ? 32'h20 : 32'h0) | (p[0] ? 32'h100 : 32'h0);
        return (ms & ~32'h1888) | (ms[3] ? 32'h80 : 32'h0) | (32'(p) << 11);
    endfunction

    function automatic logic [31:0] ret_status(logic [31:0] ms, bit s);
        if (s) return (ms & ~32'h122) | 32'h20 | (ms[5] ? 32'h2 : 32'h0);
        return (ms & ~32'h1888) | 32'h80 | (ms[7] ? 32'h8 : 32'h0);
    endfunction

    task automatic chk_outs(input logic b, input logic we, input logic [11:0] a,
                            input logic [31:0] d, input logic rd, input logic [31:0] pc,
                            input logic [1:0] pv);
        chk("busy", busy, b);
        chk("flush", flush, b);
        chk("csr_we", csr_we, we);
        chk("csr_waddr", csr_waddr, a);
        chk("csr_wdata", csr_wdata, d);
        chk("pc_redirect", pc_redirect, rd);
        chk("priv_we", priv_we, rd);
        chk("redirect_pc", redirect_pc, pc);
        chk("new_priv", new_priv, pv);
    endtask

    always @(negedge clk) begin
        cyc++;
        if (!reset_n) begin
            wq.delete();
            in_seq = 0;
            chk_outs(0, 0, 12'h0, 32'h0, 0, 32'h0, 2'b00);
        end else if (!in_seq) begin
            chk_outs(0, 0, 12'h0, 32'h0, 0, 32'h0, 2'b00);
            if (exc_valid) begin
                bit          s;
                logic [11:0] base;
                s    = (current_priv != 2'b11) && medeleg[exc_code];
                base = s ? 12'h100 : 12'h300;
                wq.push_back('{a: base + 12'h41, d: exc_pc});
                wq.push_back('{a: base + 12'h42, d: 32'(exc_code)});
                wq.push_back('{a: base + 12'h43, d: exc_val});
                wq.push_back('{a: 12'h300, d: trap_status(mstatus_in, current_priv, s)});
                m_pc   = (s ? stvec : mtvec) & ~32'h3;
                m_priv = s ? 2'b01 : 2'b11;
                in_seq = 1;
                acc_cyc = cyc;
            end else if (xret_valid) begin
                wq.push_back('{a: 12'h300, d: ret_status(mstatus_in, xret_is_sret)});
                m_pc   = xret_is_sret ? sepc : mepc;
                m_priv = xret_is_sret ? {1'b0, mstatus_in[8]} : mstatus_in[12:11];
                in_seq = 1;
                acc_cyc = cyc;
            end
        end else if (wq.size() > 0) begin
            chk_outs(1, 1, wq[0].a, wq[0].d, 0, 32'h0, 2'b00);
            if (csr_ready) begin
                if (csr_we) obs[int'(csr_waddr)] = csr_wdata;
                void'(wq.pop_front());
            end
        end else begin
            chk_outs(1, 0, 12'h0, 32'h0, 1, m_pc, m_priv);
            if (pc_redirect) begin
                obs_pc   = redirect_pc;
                obs_priv = new_priv;
                obs_lat  = cyc - acc_cyc;
                n_redir++;
            end
            in_seq = 0;
        end
    end

    task automatic start_req(input bit e, input bit x, input bit sret);
        @(posedge clk); #1;
        exc_valid    = e;
        xret_valid   = x;
        xret_is_sret = sret;
        @(posedge clk); #1;
        exc_valid  = 0;
        xret_valid = 0;
    endtask

    task automatic wait_redirect();
        int n0;
        int i;
        n0 = n_redir;
        i  = 0;
        while (n_redir == n0 && i < 40) begin
            @(posedge clk); #1;
            i++;
        end
        chk("redirect_timeout", 64'(n_redir != n0), 64'd1);
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic wait_addr(input logic [11:0] a);
        for (int i = 0; i < 10 && csr_waddr !== a; i++) begin
            @(posedge clk); #1;
        end
        chk("wait_addr", csr_waddr, a);
    endtask

    task automatic setup(input logic [1:0] p, input logic [4:0] code, input logic [31:0] pc,
                         input logic [31:0] val, input logic [31:0] deleg, input logic [31:0] ms);
        current_priv = p;
        exc_code     = code;
        exc_pc       = pc;
        exc_val      = val;
        medeleg      = deleg;
        mstatus_in   = ms;
        obs.delete();
    endtask

    initial begin
        int n0;
        reset_n = 0; exc_valid = 0; xret_valid = 0; xret_is_sret = 0; csr_ready = 1;
        exc_code = 0; exc_pc = 0; exc_val = 0; medeleg = 0; mstatus_in = 0;
        mtvec = 32'h8000_0101; stvec = 32'h8000_2000; mepc = 32'h2000; sepc = 32'h4000;
        current_priv = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_busy", busy, 0);
        chk("reset_redirect", pc_redirect, 0);
        chk("reset_we", csr_we, 0);
        reset_n = 1;

        // U-mode ecall to M
        setup(2'b00, 5'd8, 32'h1000, 32'h0, 32'h0, 32'h8);
        start_req(1, 0, 0);
        wait_redirect();
        chk("t1_mepc", obs[32'h341], 32'h1000);
        chk("t1_mcause", obs[32'h342], 32'h8);
        chk("t1_mtval", obs[32'h343], 32'h0);
        chk("t1_mstatus", obs[32'h300], 32'h80);
        chk("t1_pc", obs_pc, 32'h8000_0100);
        chk("t1_priv", obs_priv, 2'b11);
        chk("t1_latency", obs_lat, 5);

        // S-mode load page fault delegated to S
        setup(2'b01, 5'd13, 32'h3000, 32'hDEAD_0000, 32'h1 << 13, 32'h2);
        start_req(1, 0, 0);
        wait_redirect();
        chk("t2_sepc", obs[32'h141], 32'h3000);
        chk("t2_scause", obs[32'h142], 32'd13);
        chk("t2_stval", obs[32'h143], 32'hDEAD_0000);
        chk("t2_mstatus", obs[32'h300], 32'h120);
        chk("t2_pc", obs_pc, 32'h8000_2000);
        chk("t2_priv", obs_priv, 2'b01);

        // Same fault from M-mode ignores delegation
        setup(2'b11, 5'd13, 32'h3000, 32'hDEAD_0000, 32'h1 << 13, 32'h8);
        start_req(1, 0, 0);
        wait_redirect();
        chk("t3_mcause", obs[32'h342], 32'd13);
        chk("t3_no_s_write", 64'(obs.exists(32'h142)), 64'd0);
        chk("t3_mstatus", obs[32'h300], 32'h1880);
        chk("t3_priv", obs_priv, 2'b11);

        // MRET back to S
        setup(2'b11, 5'd0, 32'h0, 32'h0, 32'h0, 32'h880);
        start_req(0, 1, 0);
        wait_redirect();
        chk("t4_mstatus", obs[32'h300], 32'h88);
        chk("t4_pc", obs_pc, 32'h2000);
        chk("t4_priv", obs_priv, 2'b01);
        chk("t4_latency", obs_lat, 2);

        // SRET back to U
        setup(2'b01, 5'd0, 32'h0, 32'h0, 32'h0, 32'h20);
        start_req(0, 1, 1);
        wait_redirect();
        chk("t4b_mstatus", obs[32'h300], 32'h22);
        chk("t4b_pc", obs_pc, 32'h4000);
        chk("t4b_priv", obs_priv, 2'b00);

        // Exception and MRET together, CSR bus stalled during the cause write
        setup(2'b00, 5'd2, 32'h5000, 32'h1234, 32'h0, 32'h8);
        start_req(1, 1, 0);
        wait_addr(12'h342);
        csr_ready = 0;
        repeat (3) @(posedge clk);
        #1;
        csr_ready = 1;
        wait_redirect();
        chk("t5_mcause", obs[32'h342], 32'd2);
        chk("t5_pc", obs_pc, 32'h8000_0100);
        chk("t5_priv", obs_priv, 2'b11);
        chk("t5_latency", obs_lat, 8);

        // Reset in the middle of a trap
        setup(2'b00, 5'd8, 32'h1000, 32'h0, 32'h0, 32'h8);
        start_req(1, 0, 0);
        wait_addr(12'h343);
        n0 = n_redir;
        reset_n = 0;
        #1;
        chk("t6_busy", busy, 0);
        chk("t6_we", csr_we, 0);
        chk("t6_addr", csr_waddr, 12'h0);
        chk("t6_redirect", pc_redirect, 0);
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1;
        repeat (2) @(posedge clk);
        #1;
        chk("t6_no_redirect", n_redir, n0);
        obs.delete();
        start_req(1, 0, 0);
        wait_redirect();
        chk("t6_mepc", obs[32'h341], 32'h1000);
        chk("t6_pc", obs_pc, 32'h8000_0100);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

`default_nettype wire
